// File: rtl/nexus_pkg.sv
// Shared constants for the NexusRV16 memory responder: MMIO register offsets and loader states.
package nexus_pkg;

  localparam logic [1:0] MMIO_LED     = 2'd0;
  localparam logic [1:0] MMIO_CYCLE   = 2'd1;
  localparam logic [1:0] MMIO_STATUS  = 2'd2;
  localparam logic [1:0] MMIO_LOADCNT = 2'd3;

  localparam logic [1:0] LD_IDLE = 2'd0;
  localparam logic [1:0] LD_HI   = 2'd1;
  localparam logic [1:0] LD_LO   = 2'd2;

  // One past the last RAM word address, widened so a 16-bit RAM still has an end marker.
  function automatic logic [16:0] ram_end(input int aw);
    return 17'd1 << aw;
  endfunction

endpackage

// File: rtl/nexus_mem_responder_if.sv
// CPU bus and loader byte stream between the core/board side (master) and the responder (slave).
interface nexus_mem_responder_if;

  logic [15:0] address;
  logic [15:0] to_memory;
  logic        write_en;
  logic [15:0] from_memory;
  logic        sel_in;
  logic        load_valid;
  logic [7:0]  load_byte;
  logic        load_ready;

  modport master (
    output address, to_memory, write_en, sel_in, load_valid, load_byte,
    input  from_memory, load_ready
  );

  modport slave (
    input  address, to_memory, write_en, sel_in, load_valid, load_byte,
    output from_memory, load_ready
  );

endinterface

// File: rtl/nexus_prog_loader.sv
// Big-endian byte-pair program loader; write request is combinational on the accepted low byte.
// Accepts a byte only on load_valid && load_ready; ready is dropped as soon as sel_in falls.
module nexus_prog_loader
  import nexus_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter logic [15:0] LOAD_BASE = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel_in,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  output logic              load_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_dat,
  output logic              ovf_set,
  output logic [15:0]       load_words
);

  localparam logic [16:0] RAM_END = ram_end(ADDR_W);

  logic [1:0]  state;
  logic [16:0] ptr;
  logic [7:0]  hi_byte;
  logic        take;
  logic        in_range;

  // Gating ready with sel_in keeps a byte from being swallowed in the abort cycle.
  assign load_ready = (state != LD_IDLE) && sel_in;
  assign take       = load_valid && load_ready;
  assign in_range   = ptr < RAM_END;

  assign wr_en   = take && (state == LD_LO) && in_range;
  assign ovf_set = take && (state == LD_LO) && !in_range;
  assign wr_addr = ptr[ADDR_W-1:0];
  assign wr_dat  = {hi_byte, load_byte};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= LD_IDLE;
      ptr        <= '0;
      hi_byte    <= '0;
      load_words <= '0;
    end else begin
      case (state)
        LD_IDLE: begin
          if (sel_in) begin
            state      <= LD_HI;
            ptr        <= {1'b0, LOAD_BASE};
            load_words <= '0;
          end
        end
        LD_HI: begin
          if (!sel_in) begin
            state <= LD_IDLE;
          end else if (take) begin
            hi_byte <= load_byte;
            state   <= LD_LO;
          end
        end
        LD_LO: begin
          if (!sel_in) begin
            state <= LD_IDLE;
          end else if (take) begin
            if (in_range) begin
              ptr        <= ptr + 17'd1;
              load_words <= load_words + 16'd1;
            end
            state <= LD_HI;
          end
        end
        default: state <= LD_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/nexus_mem_responder.sv
// Unified word RAM plus 4-register MMIO window; reads are zero-latency, writes land on the clock edge.
// The loader owns the write port while sel_in is high, so CPU stores are dropped then.
module nexus_mem_responder
  import nexus_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter logic [15:0] LOAD_BASE = 16'h0000,
  parameter logic [15:0] MMIO_BASE = 16'hFF00
) (
  input  logic                  clk,
  input  logic                  rst,
  nexus_mem_responder_if.slave  bus,
  output logic [15:0]           load_words,
  output logic                  load_overflow,
  output logic [15:0]           led_out
);

  localparam int          DEPTH   = 1 << ADDR_W;
  localparam logic [16:0] RAM_END = ram_end(ADDR_W);

  logic [15:0]       mem [DEPTH];
  logic [15:0]       cycle_cnt;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [15:0]       ld_dat;
  logic              ld_ovf;
  logic              in_ram;
  logic [15:0]       mmio_off;
  logic              mmio_hit;
  logic              cpu_we;
  logic [15:0]       rd_dat;

  nexus_prog_loader #(
    .ADDR_W    (ADDR_W),
    .LOAD_BASE (LOAD_BASE)
  ) u_loader (
    .clk        (clk),
    .rst        (rst),
    .sel_in     (bus.sel_in),
    .load_valid (bus.load_valid),
    .load_byte  (bus.load_byte),
    .load_ready (bus.load_ready),
    .wr_en      (ld_we),
    .wr_addr    (ld_addr),
    .wr_dat     (ld_dat),
    .ovf_set    (ld_ovf),
    .load_words (load_words)
  );

  assign in_ram   = {1'b0, bus.address} < RAM_END;
  assign mmio_off = bus.address - MMIO_BASE;
  assign mmio_hit = !in_ram && (mmio_off < 16'd4);
  assign cpu_we   = bus.write_en && !bus.sel_in;

  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem[ld_addr] <= ld_dat;
    end else if (cpu_we && in_ram) begin
      mem[bus.address[ADDR_W-1:0]] <= bus.to_memory;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_out       <= '0;
      load_overflow <= 1'b0;
      cycle_cnt     <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 16'd1;
      if (cpu_we && mmio_hit && mmio_off[1:0] == MMIO_LED) begin
        led_out <= bus.to_memory;
      end
      // Set wins over clear; they cannot coincide since CPU stores are blocked during loads.
      if (ld_ovf) begin
        load_overflow <= 1'b1;
      end else if (cpu_we && mmio_hit && mmio_off[1:0] == MMIO_STATUS && bus.to_memory[0]) begin
        load_overflow <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_dat = 16'h0000;
    if (in_ram) begin
      rd_dat = mem[bus.address[ADDR_W-1:0]];
    end else if (mmio_hit) begin
      case (mmio_off[1:0])
        MMIO_LED:     rd_dat = led_out;
        MMIO_CYCLE:   rd_dat = cycle_cnt;
        MMIO_STATUS:  rd_dat = {15'b0, load_overflow};
        MMIO_LOADCNT: rd_dat = load_words;
        default:      rd_dat = 16'h0000;
      endcase
    end
  end

  assign bus.from_memory = rd_dat;

endmodule

// File: tb/tb_nexus_mem_responder.sv
// Directed bench: u0 uses default parameters, u1 starts loading at 0x0FFF to reach the RAM end.
module tb_nexus_mem_responder;

  logic        clk;
  logic        rst;
  logic [15:0] lw0, lw1, led0, led1;
  logic        ov0, ov1;
  int          errors = 0;
  int          checks = 0;

  nexus_mem_responder_if b0 ();
  nexus_mem_responder_if b1 ();

  nexus_mem_responder u0 (
    .clk           (clk),
    .rst           (rst),
    .bus           (b0.slave),
    .load_words    (lw0),
    .load_overflow (ov0),
    .led_out       (led0)
  );

  nexus_mem_responder #(.LOAD_BASE(16'h0FFF)) u1 (
    .clk           (clk),
    .rst           (rst),
    .bus           (b1.slave),
    .load_words    (lw1),
    .load_overflow (ov1),
    .led_out       (led1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input bit u, input logic [15:0] a, output logic [15:0] d);
    if (u) b1.address = a; else b0.address = a;
    #1;
    d = u ? b1.from_memory : b0.from_memory;
  endtask

  task automatic wr(input bit u, input logic [15:0] a, input logic [15:0] d);
    if (u) begin
      b1.address = a; b1.to_memory = d; b1.write_en = 1'b1;
    end else begin
      b0.address = a; b0.to_memory = d; b0.write_en = 1'b1;
    end
    step();
    if (u) b1.write_en = 1'b0; else b0.write_en = 1'b0;
  endtask

  task automatic set_sel(input bit u, input logic v);
    if (u) b1.sel_in = v; else b0.sel_in = v;
  endtask

  task automatic end_stream(input bit u);
    if (u) b1.load_valid = 1'b0; else b0.load_valid = 1'b0;
  endtask

  // Waits (bounded) for ready, then presents one byte for exactly one edge.
  task automatic send(input bit u, input logic [7:0] b);
    int n = 0;
    while (!(u ? b1.load_ready : b0.load_ready) && n < 10) begin
      step();
      n++;
    end
    check("load_ready_wait", {15'b0, (u ? b1.load_ready : b0.load_ready)}, 16'h0001);
    if (u) begin
      b1.load_valid = 1'b1; b1.load_byte = b;
    end else begin
      b0.load_valid = 1'b1; b0.load_byte = b;
    end
    step();
  endtask

  logic [15:0] d, c1, c2;
  int          n;

  initial begin
    rst = 1'b0;
    b0.address = '0; b0.to_memory = '0; b0.write_en = 1'b0;
    b0.sel_in = 1'b0; b0.load_valid = 1'b0; b0.load_byte = '0;
    b1.address = '0; b1.to_memory = '0; b1.write_en = 1'b0;
    b1.sel_in = 1'b0; b1.load_valid = 1'b0; b1.load_byte = '0;

    // Power-on reset
    step(); step();
    check("por_led", led0, 16'h0000);
    check("por_ready", {15'b0, b0.load_ready}, 16'h0000);
    check("por_words", lw0, 16'h0000);
    check("por_ovf", {15'b0, ov0}, 16'h0000);
    rst = 1'b1;
    rd(0, 16'hFF01, d); check("por_cycle0", d, 16'h0000);
    repeat (5) step();
    rd(0, 16'hFF01, d); check("cycle_after5", d, 16'h0005);

    // Load session 12 34 AB CD
    set_sel(0, 1'b1);
    step();
    check("sess_ready", {15'b0, b0.load_ready}, 16'h0001);
    send(0, 8'h12);
    send(0, 8'h34);
    check("sess_words_mid", lw0, 16'h0001);
    send(0, 8'hAB);
    send(0, 8'hCD);
    end_stream(0);
    set_sel(0, 1'b0);
    step();
    check("sess_words", lw0, 16'h0002);
    check("sess_ready_idle", {15'b0, b0.load_ready}, 16'h0000);
    rd(0, 16'h0000, d); check("sess_mem0", d, 16'h1234);
    rd(0, 16'h0001, d); check("sess_mem1", d, 16'hABCD);
    rd(0, 16'hFF03, d); check("sess_loadcnt_mmio", d, 16'h0002);

    // Aborted word
    set_sel(0, 1'b1);
    step();
    send(0, 8'h55);
    end_stream(0);
    set_sel(0, 1'b0);
    step();
    rd(0, 16'h0000, d); check("abort_mem0", d, 16'h1234);
    check("abort_words", lw0, 16'h0000);
    set_sel(0, 1'b1);
    step();
    send(0, 8'h77);
    send(0, 8'h88);
    end_stream(0);
    set_sel(0, 1'b0);
    step();
    rd(0, 16'h0000, d); check("restart_mem0", d, 16'h7788);
    check("restart_words", lw0, 16'h0001);

    // CPU stores: same-cycle read sees old data
    wr(0, 16'h0010, 16'h1111);
    b0.address = 16'h0010; b0.to_memory = 16'hBEEF; b0.write_en = 1'b1;
    #1;
    check("store_same_cycle", b0.from_memory, 16'h1111);
    step();
    b0.write_en = 1'b0;
    check("store_next_cycle", b0.from_memory, 16'hBEEF);
    wr(0, 16'hFF00, 16'h00A5);
    check("led_write", led0, 16'h00A5);
    rd(0, 16'hFF00, d); check("led_read", d, 16'h00A5);
    wr(0, 16'h0020, 16'hCAFE);
    set_sel(0, 1'b1);
    wr(0, 16'h0020, 16'hDEAD);
    wr(0, 16'hFF00, 16'h0F0F);
    set_sel(0, 1'b0);
    step();
    rd(0, 16'h0020, d); check("store_blocked", d, 16'hCAFE);
    check("led_blocked", led0, 16'h00A5);

    // Unmapped reads and counter delta
    rd(0, 16'h2000, d); check("unmapped_2000", d, 16'h0000);
    rd(0, 16'hFF04, d); check("unmapped_ff04", d, 16'h0000);
    step();
    rd(0, 16'hFF01, c1);
    repeat (7) step();
    rd(0, 16'hFF01, c2);
    check("cycle_delta7", c2 - c1, 16'h0007);

    // Reset in the middle of a load
    wr(0, 16'hFF00, 16'h1234);
    set_sel(0, 1'b1);
    step();
    send(0, 8'h9A);
    end_stream(0);
    rst = 1'b0;
    #1;
    check("midrst_led", led0, 16'h0000);
    check("midrst_ready", {15'b0, b0.load_ready}, 16'h0000);
    check("midrst_words", lw0, 16'h0000);
    set_sel(0, 1'b0);
    step();
    rst = 1'b1;
    rd(0, 16'hFF01, d); check("midrst_cycle0", d, 16'h0000);
    rd(0, 16'h0000, d); check("midrst_mem_kept", d, 16'h7788);

    // Overflow at RAM end (u1 loads from 0x0FFF)
    set_sel(1, 1'b1);
    step();
    send(1, 8'h11);
    send(1, 8'h22);
    send(1, 8'h33);
    send(1, 8'h44);
    check("ovf_flag", {15'b0, ov1}, 16'h0001);
    check("ovf_words", lw1, 16'h0001);
    end_stream(1);
    set_sel(1, 1'b0);
    step();
    rd(1, 16'h0FFF, d); check("ovf_mem_fff", d, 16'h1122);
    rd(1, 16'hFF02, d); check("ovf_status", d, 16'h0001);
    wr(1, 16'hFF02, 16'h0000);
    check("ovf_keep_on_zero", {15'b0, ov1}, 16'h0001);
    wr(1, 16'hFF02, 16'h0001);
    check("ovf_cleared", {15'b0, ov1}, 16'h0000);
    rd(1, 16'hFF02, d); check("ovf_status_clr", d, 16'h0000);

    // Counter wrap FFFF -> 0000
    step();
    rd(0, 16'hFF01, c1);
    n = int'(16'hFFFE - c1);
    repeat (n) step();
    rd(0, 16'hFF01, d); check("wrap_fffe", d, 16'hFFFE);
    step();
    rd(0, 16'hFF01, d); check("wrap_ffff", d, 16'hFFFF);
    step();
    rd(0, 16'hFF01, d); check("wrap_0000", d, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
